// File: rtl/ccff_bitstream_loader.sv
`timescale 1ns/1ps
// ccff_bitstream_loader
// Serialises bitstream words onto the configuration flip-flop chain head and
// packs the chain tail back into readback words.
//
// Ports
//   prog_clk, prog_rst_n   programming clock, async active-low reset
//   start                  begin a load (IDLE only)
//   word_data/valid/ready  bitstream word handshake, bit 0 shifted first
//   ccff_head, ccff_en     serial data and shift enable into the chain
//   ccff_tail              serial data out of the chain
//   tail_data, tail_valid  packed readback word, LSB = first captured bit
//   busy, done             load in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// FETCH | word_ready high, waiting for a word
// SHIFT | one chain bit per cycle from the shift register
// FIN   | done pulse, back to IDLE
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024,
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] tail_data,
  output logic              tail_valid,
  output logic              busy,
  output logic              done
);

  localparam int WC_W = $clog2(WORD_W + 1);
  localparam int PK_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FIN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q;
  logic [WC_W-1:0]   word_left_q;
  logic [WORD_W-1:0] shreg_q;
  logic [PK_W-1:0]   pack_cnt_q;
  logic [WORD_W-1:0] tail_acc_q, tail_acc_nxt;
  logic              last_bit, word_end, pack_end;

  assign last_bit = (remaining_q == CNT_W'(1));
  assign word_end = (word_left_q == WC_W'(1));
  assign pack_end = (pack_cnt_q == PK_W'(WORD_W - 1));

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    word_ready = 1'b0;
    ccff_en    = 1'b0;
    ccff_head  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: begin
        word_ready = 1'b1;
        if (word_valid) state_d = SHIFT;
      end
      SHIFT: begin
        ccff_en   = 1'b1;
        ccff_head = shreg_q[0];
        if (word_end) state_d = last_bit ? FIN : FETCH;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word datapath: remaining and word_left are down-counters; a partial final
  // word loads word_left with the residue so its upper bits never shift out.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      remaining_q <= '0;
      word_left_q <= '0;
      shreg_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) remaining_q <= CNT_W'(CHAIN_LEN);
        FETCH: if (word_valid) begin
          shreg_q <= word_data;
          if (32'(remaining_q) < WORD_W) word_left_q <= WC_W'(remaining_q);
          else                           word_left_q <= WC_W'(WORD_W);
        end
        SHIFT: begin
          shreg_q     <= shreg_q >> 1;
          remaining_q <= remaining_q - CNT_W'(1);
          word_left_q <= word_left_q - WC_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tail_acc_nxt             = tail_acc_q;
    tail_acc_nxt[pack_cnt_q] = ccff_tail;
  end

  // Readback packing; the accumulator is cleared whenever a word is emitted,
  // which leaves the unfilled upper bits of a partial final word at 0.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      pack_cnt_q <= '0;
      tail_acc_q <= '0;
      tail_data  <= '0;
      tail_valid <= 1'b0;
    end else begin
      tail_valid <= 1'b0;
      if (state_q == IDLE && start) begin
        pack_cnt_q <= '0;
        tail_acc_q <= '0;
      end else if (ccff_en) begin
        if (pack_end || last_bit) begin
          tail_data  <= tail_acc_nxt;
          tail_valid <= 1'b1;
          pack_cnt_q <= '0;
          tail_acc_q <= '0;
        end else begin
          tail_acc_q <= tail_acc_nxt;
          pack_cnt_q <= pack_cnt_q + PK_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

  logic       prog_clk = 1'b0;
  logic       prog_rst_n;
  logic       start;
  logic [7:0] word_data;
  logic       word_valid;

  logic       word_ready, ccff_head, ccff_en, ccff_tail, tail_valid, busy, done;
  logic [7:0] tail_data;
  logic       word_ready_b, ccff_head_b, ccff_en_b, ccff_tail_b, tail_valid_b, busy_b, done_b;
  logic [7:0] tail_data_b;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .ccff_en(ccff_en), .ccff_tail(ccff_tail),
    .tail_data(tail_data), .tail_valid(tail_valid), .busy(busy), .done(done)
  );

  // Second instance shares the inputs; it only takes the first two words.
  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut16 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready_b),
    .ccff_head(ccff_head_b), .ccff_en(ccff_en_b), .ccff_tail(ccff_tail_b),
    .tail_data(tail_data_b), .tail_valid(tail_valid_b), .busy(busy_b), .done(done_b)
  );

  // Chain models, preloaded with all ones
  logic [19:0] chain_a;
  logic [15:0] chain_b;
  logic        preload;
  always @(posedge prog_clk) begin
    if (preload) begin
      chain_a <= '1;
      chain_b <= '1;
    end else begin
      if (ccff_en)   chain_a <= {chain_a[18:0], ccff_head};
      if (ccff_en_b) chain_b <= {chain_b[14:0], ccff_head_b};
    end
  end
  assign ccff_tail   = chain_a[19];
  assign ccff_tail_b = chain_b[15];

  // Output monitor, sampled on the falling edge
  logic       mon_clr;
  logic [31:0] head_seq, head_seq_b;
  int en_cnt, done_cnt, done_ok, tv_done, idle_head_bad;
  int en_cnt_b, done_ok_b;
  logic prev_en, prev_en_b;
  logic [7:0] tv_q[$];
  logic [7:0] tv_q_b[$];

  always @(negedge prog_clk) begin
    if (mon_clr) begin
      head_seq = '0; head_seq_b = '0;
      en_cnt = 0; done_cnt = 0; done_ok = 0; tv_done = 0; idle_head_bad = 0;
      en_cnt_b = 0; done_ok_b = 0; prev_en = 1'b0; prev_en_b = 1'b0;
      tv_q.delete(); tv_q_b.delete();
    end else begin
      if (ccff_en) begin
        if (en_cnt < 32) head_seq[en_cnt] = ccff_head;
        en_cnt++;
      end else if (ccff_head !== 1'b0) idle_head_bad++;
      if (ccff_en_b) begin
        if (en_cnt_b < 32) head_seq_b[en_cnt_b] = ccff_head_b;
        en_cnt_b++;
      end
      if (done) begin
        done_cnt++;
        if (prev_en && !ccff_en) done_ok++;
        if (tail_valid) tv_done++;
      end
      if (done_b && prev_en_b && !ccff_en_b) done_ok_b++;
      if (tail_valid)   tv_q.push_back(tail_data);
      if (tail_valid_b) tv_q_b.push_back(tail_data_b);
      prev_en   = ccff_en;
      prev_en_b = ccff_en_b;
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    preload = 1'b1;
    mon_clr = 1'b1;
    @(posedge prog_clk); #1;
    preload = 1'b0;
    @(negedge prog_clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    bit ok = 0;
    word_data  = w;
    word_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge prog_clk);
      if (word_ready) begin
        @(posedge prog_clk); #1;
        ok = 1;
      end
    end
    if (!ok) chk("word_timeout", 0, 1);
  endtask

  task automatic stall5();
    bit ok = 0;
    int bad = 0;
    word_valid = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge prog_clk); #2;
      if (word_ready) ok = 1;
    end
    if (!ok) chk("stall_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (ccff_en !== 1'b0 || ccff_head !== 1'b0 || word_ready !== 1'b1) bad++;
      @(posedge prog_clk); #2;
    end
    chk("stall_quiet", bad, 0);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge prog_clk); #2;
      if (done) ok = 1;
    end
    if (!ok) chk("done_timeout", 0, 1);
    chk("busy_in_fin", busy, 1);
    @(posedge prog_clk); #2;
    chk("busy_after_fin", {busy, done}, 0);
  endtask

  // Three-word load on the 20-bit instance; optional stalls and a stray start
  task automatic run_load(input logic [7:0] w0, w1, w2, input bit stall, input bit restart);
    clear_mon();
    pulse_start();
    send_word(w0);
    if (restart) begin
      start = 1'b1;
      @(posedge prog_clk); #1 start = 1'b0;
    end
    if (stall) stall5();
    send_word(w1);
    if (stall) stall5();
    send_word(w2);
    word_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    prog_rst_n = 1'b0; start = 1'b0; word_data = '0; word_valid = 1'b0;
    preload = 1'b0; mon_clr = 1'b1;
    #1;
    chk("rst_outputs", {busy, done, ccff_en, ccff_head, word_ready, tail_valid, tail_data}, 0);
    #20 prog_rst_n = 1'b1;

    // Test 1/2: straight load and readback of preloaded ones
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 0);
    chk("t1_head_seq", head_seq[19:0], 20'hF3CA5);
    chk("t1_en_cnt", en_cnt, 20);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_after_en", done_ok, 1);
    chk("t1_idle_head", idle_head_bad, 0);
    chk("t2_tv_cnt", tv_q.size(), 3);
    if (tv_q.size() == 3) begin
      chk("t2_tv0", tv_q[0], 8'hFF);
      chk("t2_tv1", tv_q[1], 8'hFF);
      chk("t2_tv2", tv_q[2], 8'h0F);
    end
    chk("t2_tv_with_done", tv_done, 1);

    // Test 3: source stalls in FETCH
    run_load(8'hA5, 8'h3C, 8'h0F, 1, 0);
    chk("t3_head_seq", head_seq[19:0], 20'hF3CA5);
    chk("t3_en_cnt", en_cnt, 20);
    chk("t3_idle_head", idle_head_bad, 0);

    // Test 4: reset during the second word's shift
    clear_mon();
    pulse_start();
    send_word(8'hA5);
    send_word(8'h3C);
    @(posedge prog_clk); #2;
    chk("t4_pre_rst_en", ccff_en, 1);
    prog_rst_n = 1'b0;
    #1;
    chk("t4_rst_outputs", {busy, done, ccff_en, ccff_head, word_ready, tail_valid, tail_data}, 0);
    word_valid = 1'b0;
    #10 prog_rst_n = 1'b1;
    @(posedge prog_clk); #2;
    chk("t4_idle_after_rst", {busy, word_ready, ccff_en}, 0);
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 0);
    chk("t4_reload_seq", head_seq[19:0], 20'hF3CA5);
    chk("t4_reload_en", en_cnt, 20);

    // Test 5: word_valid in IDLE and a stray start mid-load
    word_data = 8'hEE; word_valid = 1'b1;
    begin
      int bad = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge prog_clk); #2;
        if (busy !== 1'b0 || word_ready !== 1'b0 || ccff_en !== 1'b0) bad++;
      end
      chk("t5_idle_valid", bad, 0);
    end
    word_valid = 1'b0;
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 1);
    chk("t5_head_seq", head_seq[19:0], 20'hF3CA5);
    chk("t5_en_cnt", en_cnt, 20);
    chk("t5_done_cnt", done_cnt, 1);
    repeat (3) @(posedge prog_clk);
    #2 chk("t5_no_extra_done", {done_cnt, 1'b0, busy}, {32'd1, 2'b00});

    // Test 6: 16-bit chain instance, runs alongside a fresh load
    run_load(8'h01, 8'h80, 8'h55, 0, 0);
    chk("t6_head_seq", head_seq_b[15:0], 16'h8001);
    chk("t6_en_cnt", en_cnt_b, 16);
    chk("t6_tv_cnt", tv_q_b.size(), 2);
    if (tv_q_b.size() == 2) begin
      chk("t6_tv0", tv_q_b[0], 8'hFF);
      chk("t6_tv1", tv_q_b[1], 8'hFF);
    end
    chk("t6_done_after_en", done_ok_b, 1);
    chk("t6_busy", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
